// File: rtl/demux_pkg.sv
// Shared constants and types for the 1-to-4 stream demultiplexer.
package demux_pkg;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned SEL_W  = 2;
  localparam int unsigned CNT_W  = 8;

  typedef logic [SEL_W-1:0] ch_sel_t;

endpackage

// File: rtl/demux_slot.sv
// One-entry output slot: a load always wins over a take, which gives
// bubble-free pass-through when a slot is filled and drained in the same cycle.
module demux_slot #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             take,
  output logic             valid,
  output logic [WIDTH-1:0] q
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] q_q, q_d;

  always_comb begin
    valid_d = valid_q;
    q_d     = q_q;
    if (load) begin
      valid_d = 1'b1;
      q_d     = d;
    end else if (take) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      q_q     <= '0;
    end else begin
      valid_q <= valid_d;
      q_q     <= q_d;
    end
  end

  assign valid = valid_q;
  assign q     = q_q;

endmodule

// File: rtl/demux4_stream.sv
// Registered 1-to-4 valid/ready demultiplexer with independent per-channel slots.
// Define DEMUX_CNT_EN to add the per-channel delivered-word counters cnt0..cnt3.
module demux4_stream
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  input  ch_sel_t           sel,
  output logic [NUM_CH-1:0] out_valid,
  input  logic [NUM_CH-1:0] out_ready,
  output logic [WIDTH-1:0]  data0,
  output logic [WIDTH-1:0]  data1,
  output logic [WIDTH-1:0]  data2,
  output logic [WIDTH-1:0]  data3
`ifdef DEMUX_CNT_EN
  ,
  output logic [CNT_W-1:0]  cnt0,
  output logic [CNT_W-1:0]  cnt1,
  output logic [CNT_W-1:0]  cnt2,
  output logic [CNT_W-1:0]  cnt3
`endif
);

  logic [WIDTH-1:0]  slot_q [NUM_CH];
  logic [NUM_CH-1:0] load;
  logic [NUM_CH-1:0] take;

  // Only the addressed channel can stall the producer.
  assign in_ready = !out_valid[sel] || out_ready[sel];

  always_comb begin
    load = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      load[i] = in_valid && in_ready && (sel == ch_sel_t'(i));
    end
  end

  assign take = out_valid & out_ready;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_slot
    demux_slot #(
      .WIDTH(WIDTH)
    ) u_slot (
      .clk  (clk),
      .rst_n(rst_n),
      .load (load[g]),
      .d    (in_data),
      .take (take[g]),
      .valid(out_valid[g]),
      .q    (slot_q[g])
    );
  end

  assign data0 = slot_q[0];
  assign data1 = slot_q[1];
  assign data2 = slot_q[2];
  assign data3 = slot_q[3];

`ifdef DEMUX_CNT_EN
  logic [CNT_W-1:0] cnt_q [NUM_CH];
  logic [CNT_W-1:0] cnt_d [NUM_CH];

  // Free-running wrap from 255 to 0.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_d[i] = cnt_q[i] + CNT_W'(take[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign cnt0 = cnt_q[0];
  assign cnt1 = cnt_q[1];
  assign cnt2 = cnt_q[2];
  assign cnt3 = cnt_q[3];
`endif

endmodule
